uart_rx: RTL and testbench

- Serial receive front end sitting directly upstream of the core's byte consumer; decodes the asynchronous `rx` pin into bytes.
- Frame format: 8N1 (start, 8 data bits LSB first, 1 stop); optional even-parity bit.
- Delivers each byte on a valid/ready handshake through a one-entry holding register.
- Reports framing, overrun and (optionally) parity errors as single-cycle pulses.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// d16_uart_pkg: shared types and constants for the UART receive slice.
//   state_t     receiver FSM states
//   DEFAULT_DIV clocks per bit at 50 MHz / 115200 baud
//   DATA_BITS   payload bits per frame
package d16_uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DEFAULT_DIV = 434;
    localparam int DATA_BITS   = 8;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery handshake plus error pulses from the receiver.
//   data/valid  received byte, held until valid&&ready
//   ready       consumer accepts data
//   frame_err, overrun, parity_err  one-cycle error pulses
//   master = receiver side, slave = consumer side
interface uart_rx_if;
    import d16_uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 parity_err;

    modport master (output data, valid, frame_err, overrun, parity_err, input ready);
    modport slave  (input data, valid, frame_err, overrun, parity_err, output ready);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous input pin.
//   clk, rst_n  clock, async active-low reset (flops reset to 1 = line idle)
//   d           asynchronous input
//   q           synchronized output, 2-cycle latency
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register.
//   clk, rst_n  clock, async active-low reset
//   rx          raw serial line (idle high, asynchronous)
//   rx_if       master side of uart_rx_if: data/valid/ready + error pulses
// Build option: define UART_RX_PARITY_EN to require an even-parity bit
// between the data bits and the stop bit.
module uart_rx
    import d16_uart_pkg::*;
#(
    parameter  int DIV   = DEFAULT_DIV,
    localparam int CNT_W = $clog2(DIV)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master rx_if
);
    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 cnt_zero, last_bit, par_bad;

    logic cnt_start, cnt_run, shift_en, byte_done, stop_bad, par_chk;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, frame_err_q, overrun_q;

    uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));

    assign cnt_zero = (cnt == '0);
    assign last_bit = (bit_idx == 3'(DATA_BITS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_HIGH;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (cnt_zero) state_nxt = rx_s ? IDLE : DATA;   // high at mid-start = glitch
`ifdef UART_RX_PARITY_EN
            DATA:      if (cnt_zero && last_bit) state_nxt = PARITY;
            PARITY:    if (cnt_zero) state_nxt = STOP;
`else
            DATA:      if (cnt_zero && last_bit) state_nxt = STOP;
`endif
            STOP:      if (cnt_zero) state_nxt = rx_s ? IDLE : WAIT_HIGH;
            default:   state_nxt = WAIT_HIGH;
        endcase
    end

    // Control strobes
    always_comb begin
        cnt_start = 1'b0;
        cnt_run   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        par_chk   = 1'b0;
        case (state)
            IDLE:   cnt_start = !rx_s;
            START:  cnt_run = 1'b1;
            DATA:   begin cnt_run = 1'b1; shift_en = cnt_zero; end
            PARITY: begin cnt_run = 1'b1; par_chk = cnt_zero && ((^shreg) ^ rx_s); end
            STOP:   begin
                cnt_run   = 1'b1;
                byte_done = cnt_zero && rx_s && !par_bad;
                stop_bad  = cnt_zero && !rx_s;
            end
            default: ;
        endcase
    end

    // Bit timing and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (cnt_start)    cnt <= CNT_W'(DIV / 2 - 1);   // first sample lands mid start bit
            else if (cnt_run) cnt <= cnt_zero ? CNT_W'(DIV - 1) : cnt - 1'b1;

            if (state == START && cnt_zero) bit_idx <= '0;
            else if (shift_en)               bit_idx <= bit_idx + 1'b1;

            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};   // LSB arrives first
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    // Parity verdict is kept until the stop bit so the byte can be dropped there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= par_chk;
            if (state == PARITY && cnt_zero) par_bad <= par_chk;
        end
    end

    assign rx_if.parity_err = parity_err_q;
`else
    assign par_bad          = 1'b0;
    assign rx_if.parity_err = 1'b0;
`endif

    // Holding register: a completing byte may replace data only if the slot
    // is empty or being drained in the same cycle; otherwise it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= byte_done && valid_q && !rx_if.ready;
            if (byte_done && (!valid_q || rx_if.ready)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && rx_if.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.valid     = valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames (directed + randomized) into uart_rx and
// checks every cycle against a frame-timing model: each frame sent at cycle
// t0 produces its outcome at t0 + 2 + DIV/2 + n*DIV + 1, where n is the index
// of the deciding bit; the holding register is modelled as a single slot.
module tb_uart_rx;
    import d16_uart_pkg::*;

    localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR     = 1;
    localparam int LAT_LIT = 171;
`else
    localparam int PAR     = 0;
    localparam int LAT_LIT = 155;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .rx(rx), .rx_if(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = byte complete, 1 = frame error, 2 = parity error
    typedef struct {
        int         at;
        int         kind;
        logic [7:0] b;
    } ev_t;
    ev_t evq[$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model + per-cycle compare ----------------
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       rdy_prev  = 1'b0;
    logic       vld_prev  = 1'b0;
    int         rise_cyc  = -1;
    int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    logic       e_fe, e_ov, e_pe, e_done;
    logic [7:0] e_b;
    ev_t        ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            chk("rst_valid", bus.valid, 1'b0);
            chk("rst_data", bus.data, 8'h00);
            chk("rst_pulses", {bus.frame_err, bus.overrun, bus.parity_err}, 3'b000);
        end else begin
            e_fe = 0; e_ov = 0; e_pe = 0; e_done = 0; e_b = 8'h00;
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                ev = evq.pop_front();
                chk("event_time", ev.at, cyc);
                case (ev.kind)
                    0: begin e_done = 1; e_b = ev.b; end
                    1: e_fe = 1;
                    default: e_pe = 1;
                endcase
            end
            if (e_done) begin
                if (!exp_valid || rdy_prev) begin
                    exp_valid = 1'b1;
                    exp_data  = e_b;
                end else e_ov = 1'b1;
            end else if (exp_valid && rdy_prev) exp_valid = 1'b0;

            chk("valid", bus.valid, exp_valid);
            chk("data", bus.data, exp_data);
            chk("frame_err", bus.frame_err, e_fe);
            chk("overrun", bus.overrun, e_ov);
            chk("parity_err", bus.parity_err, e_pe);

            if (bus.valid && !vld_prev) rise_cyc = cyc;
            if (bus.frame_err)  fe_cnt++;
            if (bus.overrun)    ov_cnt++;
            if (bus.parity_err) pe_cnt++;
        end
        rdy_prev = bus.ready;
        vld_prev = bus.valid;
    end

    // ---------------- ready driver ----------------
    logic rnd_rdy   = 1'b0;
    logic ready_cmd = 1'b1;

    initial begin
        bus.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ready = rnd_rdy ? 1'($urandom_range(0, 1)) : ready_cmd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // Outcome visible 2 (sync) + 1 (idle detect) + DIV/2 + n*DIV cycles after the start edge.
    function automatic int outcome_at(input int t0, input int n);
        return t0 + 3 + DIV / 2 + n * DIV;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok,
                              input int hold_low);
        int   t0;
        logic pbad;
        t0   = cyc;
        pbad = (PAR == 1) && !par_ok;
        if (pbad)  evq.push_back('{outcome_at(t0, 9), 2, b});
        if (!stop) evq.push_back('{outcome_at(t0, 9 + PAR), 1, b});
        else if (!pbad) evq.push_back('{outcome_at(t0, 9 + PAR), 0, b});
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        if (PAR == 1) begin
            rx = (^b) ^ !par_ok;
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
        if (!stop) begin
            tick(hold_low);
            idle(20);
        end
    endtask

    task automatic glitch();
        rx = 1'b0;
        tick(4);
        idle(30);
    endtask

    // ---------------- main sequence ----------------
    int t0, base_fe, base_ov, base_pe, base_rise;

    initial begin
        tick(3);
        chk("lit_reset_valid", bus.valid, 1'b0);
        chk("lit_reset_data", bus.data, 8'h00);
        rst_n = 1'b1;
        idle(10);

        // 0xA5: latency and data pinned by literals
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        idle(5);
        chk("lit_a5_latency", rise_cyc - t0, LAT_LIT);
        chk("lit_a5_data", bus.data, 8'hA5);

        // short low pulse rejected, then 0x3C
        base_rise = rise_cyc;
        glitch();
        chk("lit_glitch_no_valid", rise_cyc, base_rise);
        send_frame(8'h3C, 1'b1, 1'b1, 0);
        idle(5);
        chk("lit_3c_data", bus.data, 8'h3C);

        // bad stop bit, line low 50 cycles from stop start, then 0x55
        base_fe = fe_cnt;
        base_rise = rise_cyc;
        send_frame(8'h3C, 1'b0, 1'b1, 50 - DIV);
        chk("lit_fe_count", fe_cnt - base_fe, 1);
        chk("lit_fe_no_valid", rise_cyc, base_rise);
        send_frame(8'h55, 1'b1, 1'b1, 0);
        idle(5);
        chk("lit_55_data", bus.data, 8'h55);

        // overrun with consumer stalled
        ready_cmd = 1'b0;
        idle(2);
        base_ov = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b1, 0);
        send_frame(8'h22, 1'b1, 1'b1, 0);
        idle(5);
        chk("lit_ovr_count", ov_cnt - base_ov, 1);
        chk("lit_ovr_valid", bus.valid, 1'b1);
        chk("lit_ovr_data", bus.data, 8'h11);
        ready_cmd = 1'b1;
        idle(4);
        chk("lit_drain_valid", bus.valid, 1'b0);
        chk("lit_drain_data", bus.data, 8'h11);

        // reset during data bit 3 of 0x7E
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h7E >> i);
            tick(DIV);
        end
        rx = 1'b1;
        tick(DIV / 2);
        evq.delete();
        rst_n = 1'b0;
        #1;
        chk("lit_async_rst_valid", bus.valid, 1'b0);
        chk("lit_async_rst_data", bus.data, 8'h00);
        idle(3);
        rst_n = 1'b1;
        idle(10);
        send_frame(8'h7E, 1'b1, 1'b1, 0);
        idle(5);
        chk("lit_7e_data", bus.data, 8'h7E);

`ifdef UART_RX_PARITY_EN
        base_pe = pe_cnt;
        base_rise = rise_cyc;
        send_frame(8'h07, 1'b1, 1'b0, 0);
        idle(5);
        chk("lit_par_bad_count", pe_cnt - base_pe, 1);
        chk("lit_par_bad_no_valid", rise_cyc, base_rise);
        send_frame(8'h07, 1'b1, 1'b1, 0);
        idle(5);
        chk("lit_par_ok_data", bus.data, 8'h07);
`else
        base_pe = pe_cnt;
`endif

        // randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) glitch();
            else if (r == 1) send_frame(8'($urandom), 1'b0, 1'b1, int'($urandom_range(0, 40)));
            else send_frame(8'($urandom), 1'b1, ($urandom_range(0, 3) != 0), 0);
            idle(int'($urandom_range(0, 10)));
        end
        rnd_rdy = 1'b0;
        ready_cmd = 1'b1;
        idle(40);
        chk("events_drained", evq.size(), 0);
`ifndef UART_RX_PARITY_EN
        chk("lit_no_parity_pulses", pe_cnt - base_pe, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
